lcd_frame_monitor: RTL

Parametrised, synthesisable observer for the LCD panel interface (RGB, DEN, HSD, VSD) driven by the Julia renderer. It measures the sampled video stream per frame: active line length, line count and horizontal period, plus a 32-bit pixel checksum. It flags geometry errors and sits beside the LCD output path, usable both in simulation benches and on-chip (LEDG debug).

---
 rtl/lcd_frame_monitor.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lcd_frame_monitor.sv
`default_nettype none
// ============================================================================
// Module   : lcd_frame_monitor
// Purpose  : Per-frame geometry, period and pixel-checksum observer for an
//            LCD RGB/DEN/HSD/VSD stream sampled on pixel-clock enables.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_frame_monitor #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int DATA_W   = 24,
    parameter int CNT_W    = 12,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_ce,
    input  logic              de,
    input  logic              hsync,
    input  logic              vsync,
    input  logic [DATA_W-1:0] rgb,
    input  logic              clr_err,
    output logic              locked,
    output logic              frame_done,
    output logic [31:0]       frame_sum,
    output logic [CNT_W-1:0]  line_count,
    output logic [CNT_W-1:0]  line_len,
    output logic [CNT_W-1:0]  h_total,
    output logic [15:0]       frame_count,
    output logic              err_hlen,
    output logic              err_vlen
);
    localparam logic [0:0]       WAIT_SYNC = 1'b0;
    localparam logic [0:0]       IN_FRAME  = 1'b1;
    localparam logic [CNT_W-1:0] C_H_EXP   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] C_V_EXP   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic             r_de_q;
    logic             r_hs_q;
    logic             r_vs_q;
    logic [CNT_W-1:0] r_pix_cnt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_line_cnt;
    logic [31:0]      r_acc;

    logic             w_in_frame;
    logic             w_vs_edge;
    logic             w_hs_edge;
    logic             w_boundary;
    logic             w_line_close;
    logic             w_hlen_bad;
    logic             w_vlen_bad;
    logic [CNT_W-1:0] w_pix_inc;
    logic [CNT_W-1:0] w_hcnt_inc;
    logic [CNT_W-1:0] w_line_total;
    logic [CNT_W-1:0] w_start_cnt;
    logic [31:0]      w_pix_val;
    logic [31:0]      w_start_acc;

    assign w_in_frame   = (r_state == IN_FRAME);
    assign w_vs_edge    = pix_ce && (vsync == SYNC_POL) && (r_vs_q != SYNC_POL);
    assign w_hs_edge    = pix_ce && (hsync == SYNC_POL) && (r_hs_q != SYNC_POL);
    assign w_boundary   = w_in_frame && w_vs_edge;
    // A line closes on a DE fall, or is force-closed by the frame boundary.
    assign w_line_close = w_in_frame && pix_ce && r_de_q && (!de || w_vs_edge);
    assign w_pix_inc    = r_pix_cnt + CNT_W'(r_pix_cnt != C_CNT_MAX);
    assign w_hcnt_inc   = r_hcnt + CNT_W'(r_hcnt != C_CNT_MAX);
    assign w_line_total = r_line_cnt + CNT_W'(w_line_close && (r_line_cnt != C_CNT_MAX));
    assign w_hlen_bad   = w_line_close && (r_pix_cnt != C_H_EXP);
    assign w_vlen_bad   = w_boundary && (w_line_total != C_V_EXP);
    assign w_pix_val    = 32'(rgb);
    assign w_start_cnt  = CNT_W'(de);
    assign w_start_acc  = de ? w_pix_val : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= WAIT_SYNC;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WAIT_SYNC: if (w_vs_edge) w_next_state = IN_FRAME;
            default:   w_next_state = IN_FRAME;
        endcase
    end

    always_comb begin
        locked = (r_state == IN_FRAME);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_de_q <= 1'b0;
            r_hs_q <= !SYNC_POL;
            r_vs_q <= !SYNC_POL;
        end else if (pix_ce) begin
            r_de_q <= de;
            r_hs_q <= hsync;
            r_vs_q <= vsync;
        end
    end

    // A vsync edge (entry or boundary) restarts accumulation; the edge pixel belongs to the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt  <= '0;
            r_acc      <= '0;
            r_line_cnt <= '0;
            r_hcnt     <= '0;
        end else begin
            if (w_vs_edge) begin
                r_pix_cnt  <= w_start_cnt;
                r_acc      <= w_start_acc;
                r_line_cnt <= '0;
            end else if (w_in_frame && pix_ce) begin
                r_line_cnt <= w_line_total;
                if (de) begin
                    r_pix_cnt <= w_pix_inc;
                    r_acc     <= r_acc + w_pix_val;
                end else begin
                    r_pix_cnt <= '0;
                end
            end
            if (w_in_frame && pix_ce) r_hcnt <= w_hs_edge ? '0 : w_hcnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done  <= 1'b0;
            frame_sum   <= '0;
            line_count  <= '0;
            line_len    <= '0;
            h_total     <= '0;
            frame_count <= '0;
        end else begin
            frame_done <= w_boundary;
            if (w_line_close)             line_len <= r_pix_cnt;
            if (w_in_frame && w_hs_edge)  h_total  <= w_hcnt_inc;
            if (w_boundary) begin
                line_count  <= w_line_total;
                frame_sum   <= r_acc;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_hlen <= 1'b0;
            err_vlen <= 1'b0;
        end else begin
            if (w_hlen_bad)   err_hlen <= 1'b1;
            else if (clr_err) err_hlen <= 1'b0;
            if (w_vlen_bad)   err_vlen <= 1'b1;
            else if (clr_err) err_vlen <= 1'b0;
        end
    end
endmodule
`default_nettype wire
